// File: rtl/page_bft_pkg.sv
// Shared types and defaults for BFT leaf-page arbitration.
package page_bft_pkg;

  localparam int PKT_W     = 49;
  localparam int VALID_BIT = PKT_W - 1;
  localparam int ADDR_HI   = 47;
  localparam int ADDR_LO   = 43;
  localparam int ADDR_W    = ADDR_HI - ADDR_LO + 1;

  typedef logic [ADDR_W-1:0] leaf_addr_t;
  typedef logic [PKT_W-1:0]  pkt_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    CHECK
  } out_state_t;

endpackage

// File: rtl/page_pair_bft_arbiter_if.sv
// Packet/resend bundle between the parent BFT leaf port and the two child pages.
interface page_pair_bft_arbiter_if #(
  parameter int PKT_W = page_bft_pkg::PKT_W
);

  logic [PKT_W-1:0] din_leaf_bft2interface;
  logic [PKT_W-1:0] dout_leaf_interface2bft;
  logic             resend;
  logic [PKT_W-1:0] dout_leaf_bft2interface_0;
  logic [PKT_W-1:0] dout_leaf_bft2interface_1;
  logic [PKT_W-1:0] din_leaf_interface2bft_0;
  logic [PKT_W-1:0] din_leaf_interface2bft_1;
  logic             resend_0;
  logic             resend_1;

  modport slave (
    input  din_leaf_bft2interface, resend,
    input  din_leaf_interface2bft_0, din_leaf_interface2bft_1,
    output dout_leaf_interface2bft,
    output dout_leaf_bft2interface_0, dout_leaf_bft2interface_1,
    output resend_0, resend_1
  );

  modport master (
    output din_leaf_bft2interface, resend,
    output din_leaf_interface2bft_0, din_leaf_interface2bft_1,
    input  dout_leaf_interface2bft,
    input  dout_leaf_bft2interface_0, dout_leaf_bft2interface_1,
    input  resend_0, resend_1
  );

endinterface

// File: rtl/page_pair_bft_arbiter_fifo.sv
// Synchronous packet FIFO with a combinational head; callers gate push on !full and pop on !empty.
module page_pkt_fifo #(
  parameter int W     = 49,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE   = 1;
  localparam logic [AW:0]   CNT_ONE   = 1;
  localparam logic [AW:0]   CNT_DEPTH = DEPTH;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign full  = (count == CNT_DEPTH);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/page_pair_bft_arbiter.sv
// Shares one parent BFT leaf port between two child pages: address steering inbound,
// round-robin merge with resend retry outbound, registered reset/start fan-out.
module page_pair_bft_arbiter #(
  parameter int                         PKT_W       = page_bft_pkg::PKT_W,
  parameter int                         ADDR_HI     = page_bft_pkg::ADDR_HI,
  parameter int                         ADDR_LO     = page_bft_pkg::ADDR_LO,
  parameter logic [ADDR_HI-ADDR_LO:0]   CHILD0_ADDR = 5'd2,
  parameter logic [ADDR_HI-ADDR_LO:0]   CHILD1_ADDR = 5'd3,
  parameter int                         FIFO_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ap_start,
  page_pair_bft_arbiter_if.slave  bus,
  output logic                    reset_0,
  output logic                    reset_1,
  output logic                    ap_start_0,
  output logic                    ap_start_1,
  output logic [15:0]             drop_cnt
);

  import page_bft_pkg::*;

  localparam int VB = PKT_W - 1;

  logic [ADDR_HI-ADDR_LO:0] in_addr;
  logic                     in_valid;
  logic                     push_0, push_1, pop_0, pop_1;
  logic                     full_0, full_1, empty_0, empty_1;
  logic [PKT_W-1:0]         head_0, head_1;
  out_state_t               state, state_nxt;
  logic                     sel, sel_nxt;
  logic                     rr_ptr, rr_nxt;
  logic [PKT_W-1:0]         hold_reg, hold_nxt;

  always_ff @(posedge clk) begin
    reset_0    <= reset;
    reset_1    <= reset;
    ap_start_0 <= ap_start & ~reset;
    ap_start_1 <= ap_start & ~reset;
  end

  assign in_addr  = bus.din_leaf_bft2interface[ADDR_HI:ADDR_LO];
  assign in_valid = bus.din_leaf_bft2interface[VB];

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.dout_leaf_bft2interface_0 <= '0;
      bus.dout_leaf_bft2interface_1 <= '0;
      drop_cnt                      <= '0;
    end else begin
      bus.dout_leaf_bft2interface_0 <= '0;
      bus.dout_leaf_bft2interface_1 <= '0;
      if (in_valid) begin
        if (in_addr == CHILD0_ADDR)
          bus.dout_leaf_bft2interface_0 <= bus.din_leaf_bft2interface;
        else if (in_addr == CHILD1_ADDR)
          bus.dout_leaf_bft2interface_1 <= bus.din_leaf_bft2interface;
        else if (drop_cnt != '1)
          drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // full is the registered occupancy, so a same-cycle pop never frees room for a push
  assign push_0 = bus.din_leaf_interface2bft_0[VB] & ~full_0;
  assign push_1 = bus.din_leaf_interface2bft_1[VB] & ~full_1;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.resend_0 <= 1'b0;
      bus.resend_1 <= 1'b0;
    end else begin
      bus.resend_0 <= bus.din_leaf_interface2bft_0[VB] & full_0;
      bus.resend_1 <= bus.din_leaf_interface2bft_1[VB] & full_1;
    end
  end

  page_pkt_fifo #(.W(PKT_W), .DEPTH(FIFO_DEPTH)) u_fifo_0 (
    .clk   (clk),
    .reset (reset),
    .push  (push_0),
    .pop   (pop_0),
    .din   (bus.din_leaf_interface2bft_0),
    .full  (full_0),
    .empty (empty_0),
    .head  (head_0)
  );

  page_pkt_fifo #(.W(PKT_W), .DEPTH(FIFO_DEPTH)) u_fifo_1 (
    .clk   (clk),
    .reset (reset),
    .push  (push_1),
    .pop   (pop_1),
    .din   (bus.din_leaf_interface2bft_1),
    .full  (full_1),
    .empty (empty_1),
    .head  (head_1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sel      <= 1'b0;
      rr_ptr   <= 1'b0;
      hold_reg <= '0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      rr_ptr   <= rr_nxt;
      hold_reg <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt                   = state;
    sel_nxt                     = sel;
    rr_nxt                      = rr_ptr;
    hold_nxt                    = hold_reg;
    pop_0                       = 1'b0;
    pop_1                       = 1'b0;
    bus.dout_leaf_interface2bft = '0;
    case (state)
      IDLE: begin
        if (!empty_0 || !empty_1) begin
          // pointed-at child wins when non-empty, otherwise the other one
          sel_nxt   = rr_ptr ? ~empty_1 : empty_0;
          hold_nxt  = sel_nxt ? head_1 : head_0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        bus.dout_leaf_interface2bft = hold_reg;
        state_nxt                   = CHECK;
      end
      CHECK: begin
        if (bus.resend) begin
          state_nxt = SEND;
        end else begin
          pop_0     = ~sel;
          pop_1     = sel;
          rr_nxt    = ~sel;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_page_pair_bft_arbiter.sv
// Self-checking bench: inbound vector table, directed RR/resend/full/reset sequences,
// then randomized traffic against a queue-based reference model.
module tb_page_pair_bft_arbiter;

  import page_bft_pkg::*;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ap_start;
  logic        reset_0, reset_1, ap_start_0, ap_start_1;
  logic [15:0] drop_cnt;
  pkt_t        p_in, c0_in, c1_in;
  logic        rs_in;

  page_pair_bft_arbiter_if #(.PKT_W(PKT_W)) bus ();

  assign bus.din_leaf_bft2interface   = p_in;
  assign bus.din_leaf_interface2bft_0 = c0_in;
  assign bus.din_leaf_interface2bft_1 = c1_in;
  assign bus.resend                   = rs_in;

  page_pair_bft_arbiter #(.PKT_W(PKT_W), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .ap_start   (ap_start),
    .bus        (bus),
    .reset_0    (reset_0),
    .reset_1    (reset_1),
    .ap_start_0 (ap_start_0),
    .ap_start_1 (ap_start_1),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // reference model: per-child queues, RR preference, and cycles since current launch
  pkt_t        q0[$], q1[$];
  bit          rr, pick;
  int          age;
  pkt_t        hold;
  pkt_t        e_dout, e_c0, e_c1;
  bit          e_rs0, e_rs1, e_ap, e_rst;
  logic [15:0] e_drop;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endfunction

  function automatic pkt_t mk(bit v, leaf_addr_t a, logic [ADDR_LO-1:0] pl);
    return {v, a, pl};
  endfunction

  function automatic void model_step();
    bit         full0, full1;
    leaf_addr_t a;
    if (reset) begin
      q0.delete(); q1.delete();
      rr = 1'b0; age = 0; hold = '0;
      e_dout = '0; e_c0 = '0; e_c1 = '0; e_rs0 = 1'b0; e_rs1 = 1'b0;
      e_drop = '0; e_ap = 1'b0; e_rst = 1'b1;
      return;
    end
    e_rst = 1'b0;
    e_ap  = ap_start;
    full0 = (q0.size() == D);
    full1 = (q1.size() == D);
    if (age == 0) begin
      if (q0.size() != 0 || q1.size() != 0) begin
        if (!rr) pick = (q0.size() == 0);
        else     pick = (q1.size() != 0);
        hold = pick ? q1[0] : q0[0];
        age  = 1;
      end
    end else if (age == 1) begin
      age = 2;
    end else begin
      if (rs_in) age = 1;
      else begin
        if (pick) void'(q1.pop_front());
        else      void'(q0.pop_front());
        rr  = !pick;
        age = 0;
      end
    end
    e_dout = (age == 1) ? hold : '0;
    e_rs0  = c0_in[VALID_BIT] && full0;
    e_rs1  = c1_in[VALID_BIT] && full1;
    if (c0_in[VALID_BIT] && !full0) q0.push_back(c0_in);
    if (c1_in[VALID_BIT] && !full1) q1.push_back(c1_in);
    e_c0 = '0;
    e_c1 = '0;
    if (p_in[VALID_BIT]) begin
      a = p_in[ADDR_HI:ADDR_LO];
      if (a == 5'd2)             e_c0 = p_in;
      else if (a == 5'd3)        e_c1 = p_in;
      else if (e_drop != 16'hFFFF) e_drop = e_drop + 16'd1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check("dout",       64'(bus.dout_leaf_interface2bft),   64'(e_dout));
    check("child0_out", 64'(bus.dout_leaf_bft2interface_0), 64'(e_c0));
    check("child1_out", 64'(bus.dout_leaf_bft2interface_1), 64'(e_c1));
    check("resend_0",   64'(bus.resend_0), 64'(e_rs0));
    check("resend_1",   64'(bus.resend_1), 64'(e_rs1));
    check("reset_0",    64'(reset_0),      64'(e_rst));
    check("reset_1",    64'(reset_1),      64'(e_rst));
    check("ap_start_0", 64'(ap_start_0),   64'(e_ap));
    check("ap_start_1", 64'(ap_start_1),   64'(e_ap));
    check("drop_cnt",   64'(drop_cnt),     64'(e_drop));
  endtask

  typedef struct {
    pkt_t        pkt;
    pkt_t        e0;
    pkt_t        e1;
    logic [15:0] edrop;
  } vec_t;

  vec_t vt[6];
  pkt_t pa, pb, px;
  pkt_t pf[5];
  pkt_t got[$];

  initial begin
    p_in = '0; c0_in = '0; c1_in = '0; rs_in = 1'b0; ap_start = 1'b0; reset = 1'b1;
    tick();
    check("rst_reset_0", 64'(reset_0), 64'd1);
    check("rst_dout",    64'(bus.dout_leaf_interface2bft), 64'd0);
    check("rst_drop",    64'(drop_cnt), 64'd0);
    reset = 1'b0;
    tick();

    // inbound steering table
    vt[0] = '{mk(1'b1, 5'd2,  43'h111), mk(1'b1, 5'd2, 43'h111), '0,                   16'd0};
    vt[1] = '{mk(1'b1, 5'd3,  43'h222), '0,                   mk(1'b1, 5'd3, 43'h222), 16'd0};
    vt[2] = '{mk(1'b1, 5'd9,  43'h333), '0,                   '0,                   16'd1};
    vt[3] = '{mk(1'b0, 5'd9,  43'h444), '0,                   '0,                   16'd1};
    vt[4] = '{mk(1'b0, 5'd2,  43'h555), '0,                   '0,                   16'd1};
    vt[5] = '{mk(1'b1, 5'd31, 43'h666), '0,                   '0,                   16'd2};
    for (int i = 0; i < 6; i++) begin
      p_in = vt[i].pkt;
      tick();
      check("tbl_child0", 64'(bus.dout_leaf_bft2interface_0), 64'(vt[i].e0));
      check("tbl_child1", 64'(bus.dout_leaf_bft2interface_1), 64'(vt[i].e1));
      check("tbl_drop",   64'(drop_cnt), 64'(vt[i].edrop));
    end
    p_in = '0;

    // round-robin: simultaneous pushes, child 0 then child 1 three cycles apart
    pa = mk(1'b1, 5'd1, 43'hA0A0);
    pb = mk(1'b1, 5'd1, 43'hB0B0);
    c0_in = pa; c1_in = pb;
    tick();
    c0_in = '0; c1_in = '0;
    tick();
    check("rr_first",  64'(bus.dout_leaf_interface2bft), 64'(pa));
    tick(); tick(); tick();
    check("rr_second", 64'(bus.dout_leaf_interface2bft), 64'(pb));
    for (int i = 0; i < 4; i++) tick();

    // resend in CHECK re-drives child 0's packet before child 1 is served
    pa = mk(1'b1, 5'd4, 43'hA1A1);
    pb = mk(1'b1, 5'd4, 43'hB1B1);
    c0_in = pa; c1_in = pb;
    tick();
    c0_in = '0; c1_in = '0;
    tick();
    check("rs_first", 64'(bus.dout_leaf_interface2bft), 64'(pa));
    tick();
    rs_in = 1'b1;
    tick();
    check("rs_redrive", 64'(bus.dout_leaf_interface2bft), 64'(pa));
    rs_in = 1'b0;
    tick(); tick(); tick();
    check("rs_next_child1", 64'(bus.dout_leaf_interface2bft), 64'(pb));
    for (int i = 0; i < 4; i++) tick();

    // child 1 overfills while parent keeps rejecting
    for (int i = 0; i < 5; i++) pf[i] = mk(1'b1, 5'd6, 43'(32'hF00 + i));
    got.delete();
    rs_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      c1_in = pf[i];
      tick();
      if (bus.dout_leaf_interface2bft[VALID_BIT] &&
          (got.size() == 0 || got[$] != bus.dout_leaf_interface2bft))
        got.push_back(bus.dout_leaf_interface2bft);
      if (i == 3) check("full_no_resend", 64'(bus.resend_1), 64'd0);
      if (i == 4) check("full_resend_1",  64'(bus.resend_1), 64'd1);
    end
    c1_in = '0;
    for (int i = 0; i < 25; i++) begin
      if (i == 3) rs_in = 1'b0;
      tick();
      if (bus.dout_leaf_interface2bft[VALID_BIT] &&
          (got.size() == 0 || got[$] != bus.dout_leaf_interface2bft))
        got.push_back(bus.dout_leaf_interface2bft);
    end
    check("full_count", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      check("full_order", 64'(got[i]), 64'(pf[i]));

    // ap_start fan-out, then reset while a packet is being driven
    ap_start = 1'b1;
    tick();
    check("ap_start_0_hi", 64'(ap_start_0), 64'd1);
    check("ap_start_1_hi", 64'(ap_start_1), 64'd1);
    px = mk(1'b1, 5'd7, 43'h7777);
    c0_in = px;
    tick();
    c0_in = '0;
    tick();
    check("pre_reset_send", 64'(bus.dout_leaf_interface2bft), 64'(px));
    reset = 1'b1;
    tick();
    check("mid_rst_dout",  64'(bus.dout_leaf_interface2bft), 64'd0);
    check("mid_rst_r0",    64'(reset_0), 64'd1);
    check("mid_rst_r1",    64'(reset_1), 64'd1);
    check("mid_rst_drop",  64'(drop_cnt), 64'd0);
    check("mid_rst_ap0",   64'(ap_start_0), 64'd0);
    reset = 1'b0; ap_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_empty", 64'(bus.dout_leaf_interface2bft[VALID_BIT]), 64'd0);
    end

    // randomized traffic
    for (int c = 0; c < 500; c++) begin
      int         r;
      leaf_addr_t a;
      r = $urandom_range(0, 3);
      a = (r == 0) ? 5'd2 : (r == 1) ? 5'd3 : 5'($urandom);
      p_in  = mk(1'($urandom_range(0, 1)), a, 43'({$urandom, $urandom}));
      c0_in = ($urandom_range(0, 2) == 0) ? mk(1'b1, 5'($urandom), 43'({$urandom, $urandom})) : '0;
      c1_in = ($urandom_range(0, 2) == 0) ? mk(1'b1, 5'($urandom), 43'({$urandom, $urandom})) : '0;
      rs_in    = ($urandom_range(0, 3) == 0);
      ap_start = 1'($urandom_range(0, 1));
      reset    = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/page_pair_bft_arbiter.md
Name: page_pair_bft_arbiter

Overview:
- Sits between one parent BFT leaf port and the two child leaf pages of a double-subdivided page.
- Shares the single parent leaf interface between both children:
  - steers inbound packets to a child by destination address;
  - round-robin merges outbound child packets into the parent port;
  - honours the BFT resend protocol on both sides;
  - distributes registered reset/ap_start to the children.

Parameters:
- PKT_W, 49, packet width; bit PKT_W-1 is the valid flag.
- ADDR_HI, 47, MSB of destination leaf-address field.
- ADDR_LO, 43, LSB of destination leaf-address field.
- CHILD0_ADDR, 5'd2, leaf address owned by child 0.
- CHILD1_ADDR, 5'd3, leaf address owned by child 1.
- FIFO_DEPTH, 4, outbound FIFO entries per child (power of 2, ≥2).

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- din_leaf_bft2interface  in  PKT_W  packet from parent BFT.
- dout_leaf_interface2bft  out  PKT_W  packet to parent BFT.
- resend  in  1  parent rejected the packet driven in the previous cycle.
- ap_start  in  1  start request for both children.
- dout_leaf_bft2interface_0 / _1  out  PKT_W  packet to child 0 / 1.
- din_leaf_interface2bft_0 / _1  in  PKT_W  packet from child 0 / 1.
- resend_0 / resend_1  out  1  child's previous-cycle packet was not accepted.
- reset_0 / reset_1  out  1  registered reset to child.
- ap_start_0 / ap_start_1  out  1  registered start to child.
- drop_cnt  out  16  saturating count of inbound packets matching neither child.

Behaviour:
- Reset (sync, active-high):
  - all outputs 0; FIFOs empty; RR pointer = child 0; state IDLE; drop_cnt = 0.
  - Exception: reset_0/1 = 1 the cycle after reset is sampled high.
- reset_x = reset delayed 1 cycle.
- ap_start_x = ap_start delayed 1 cycle, forced 0 while reset is high.
- Inbound path, 1-cycle latency, registered:
  - valid packet with addr==CHILD0_ADDR → dout_leaf_bft2interface_0 next cycle; child 1 gets 0.
  - addr==CHILD1_ADDR → child 1 next cycle; child 0 gets 0.
  - other addr → both children get 0; drop_cnt += 1, saturating at 16'hFFFF.
  - invalid packet (valid bit 0) → both children get 0; no count.
- Child capture:
  - valid packet on din_leaf_interface2bft_x with FIFO x not full → pushed.
  - FIFO x full → packet discarded; resend_x = 1 next cycle; child redrives.
  - resend_x = 0 otherwise.
  - Push into a FIFO that is popped in the same cycle when full is not allowed: full is evaluated before the pop.
- Outbound FSM:
  - IDLE: dout = 0.
    - If any FIFO is non-empty, select by RR: the pointed-at child first, else the other.
    - Copy its head into hold_reg (no pop yet); go SEND.
  - SEND: dout = hold_reg for exactly 1 cycle; go CHECK.
  - CHECK: dout = 0; sample resend.
    - resend=1 → go SEND; re-drive the identical packet; RR pointer unchanged.
    - resend=0 → pop the selected FIFO; RR pointer = other child; go IDLE.
  - Peak outbound rate: 1 packet per 3 cycles. No retry limit.
  - resend seen in IDLE or SEND is ignored.
- Ordering: per-child packet order is preserved; no interleaving guarantee across children beyond RR.
- Reset mid-operation: in-flight hold_reg and FIFO contents are discarded; dout = 0 the next cycle.

Decomposition:
- Shared package page_bft_pkg:
  - PKT_W, VALID_BIT, ADDR_HI/ADDR_LO, leaf-address typedef.
  - outbound FSM state enum {IDLE, SEND, CHECK}.
- One sub-module: page_pkt_fifo, a synchronous FIFO (push/pop/full/empty/head, depth FIFO_DEPTH), instantiated twice.

Test Plan:
- Inbound steer: valid packet addr 5'd2 at cycle 0 → child 0 gets it at cycle 1, child 1 = 0. Addr 5'd3 → child 1. Addr 5'd9 → both 0, drop_cnt 0→1.
- Round-robin: both children push one packet at the same cycle → parent sees child 0's packet, then child 1's, 3 cycles apart.
- Resend: pulse resend in CHECK after child-0 packet → same packet re-driven in next SEND. Without resend, next winner is child 1.
- FIFO full: child 1 sends FIFO_DEPTH+1 packets back-to-back while parent holds resend=1 → 5th packet gets resend_1=1 one cycle later. FIFO contents intact; released packets arrive in order.
- Reset/start: ap_start=1 → ap_start_0/1=1 one cycle later. Assert reset mid-SEND → dout=0, reset_0/1=1, FIFOs empty, drop_cnt=0 next cycle.
